// File: rtl/memsync_assoc.sv
// memsync_assoc: tag/state controller for an N-way set-associative row cache.
// Per set it keeps valid/dirty/tag per way plus true-LRU ages. A lookup that
// hits returns the cache row {set, way} one cycle later; a miss stalls the
// requester, writes back a dirty victim, fetches the new row through the
// sync handshake, then returns the cache row of the installed line.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   RD      in   read request (level, held until served)
//   WR      in   write request (level); RD&WR is treated as WR
//   RowId   in   requested backing-memory row
//   sync    in   one-cycle ack completing the current wb or fetch
//   cRowId  out  cache row serving the request = {set, way}
//   stall   out  requester must hold RD/WR/RowId
//   hit     out  last lookup hit
//   wb      out  write-back in progress
//   fetch   out  row fetch in progress
//   mRowId  out  backing row for the current wb or fetch
module memsync_assoc #(
  parameter int unsigned CHWIDTH   = 6,
  parameter int unsigned WAYWIDTH  = 2,
  parameter int unsigned ADDRWIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 sync,
  output logic [CHWIDTH-1:0]   cRowId,
  output logic                 stall,
  output logic                 hit,
  output logic                 wb,
  output logic                 fetch,
  output logic [ADDRWIDTH-1:0] mRowId
);

  localparam int unsigned WAYS = 1 << WAYWIDTH;
  localparam int unsigned SETW = CHWIDTH - WAYWIDTH;
  localparam int unsigned SETS = 1 << SETW;
  localparam int unsigned TAGW = ADDRWIDTH - SETW;
  // Way index / age fields need at least one bit even when direct-mapped.
  localparam int unsigned WAYW = (WAYWIDTH > 0) ? WAYWIDTH : 1;
  localparam int unsigned AGEW = WAYW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_e;

  typedef logic [WAYS-1:0][AGEW-1:0] age_row_t;

  // State and storage
  state_e                                  state_q, state_d;
  logic                                    hit_q, hit_d;
  logic                                    stall_q, stall_d;
  logic                                    wb_q, wb_d;
  logic                                    fetch_q, fetch_d;
  logic [CHWIDTH-1:0]                      crow_q, crow_d;
  logic [ADDRWIDTH-1:0]                    mrow_q, mrow_d;
  logic [ADDRWIDTH-1:0]                    lrow_q, lrow_d;
  logic                                    lwr_q, lwr_d;
  logic [WAYW-1:0]                         victim_q, victim_d;
  logic [SETS-1:0][WAYS-1:0]               valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]               dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][TAGW-1:0]     tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][AGEW-1:0]     age_q, age_d;

  // Request decode and lookup results
  logic [SETW-1:0] req_set;
  logic [TAGW-1:0] req_tag;
  logic [SETW-1:0] lset;
  logic [TAGW-1:0] ltag;
  logic            req;
  logic            hit_any;
  logic [WAYW-1:0] hit_way;
  logic            inv_any;
  logic [WAYW-1:0] inv_way;
  logic [WAYW-1:0] lru_way;
  logic [WAYW-1:0] victim_way;

  assign req     = RD | WR;
  assign req_set = RowId[SETW-1:0];
  assign req_tag = RowId[ADDRWIDTH-1:SETW];
  assign lset    = lrow_q[SETW-1:0];
  assign ltag    = lrow_q[ADDRWIDTH-1:SETW];

  // Cache row {set, way}; the way field vanishes when direct-mapped.
  function automatic logic [CHWIDTH-1:0] crow_of(input logic [SETW-1:0] s,
                                                 input logic [WAYW-1:0] w);
    logic [SETW+WAYW-1:0] cat;
    cat = {s, w};
    return CHWIDTH'(cat >> (WAYW - WAYWIDTH));
  endfunction

  // Make way w most recent: everything younger than it ages by one.
  function automatic age_row_t lru_touch(input age_row_t a, input logic [WAYW-1:0] w);
    age_row_t r;
    r = a;
    for (int v = 0; v < int'(WAYS); v++) begin
      if (a[v] < a[w]) r[v] = a[v] + AGEW'(1);
    end
    r[w] = '0;
    return r;
  endfunction

  // Tag compare, lowest invalid way and LRU way for the requested set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_q[req_set][w]) begin
        inv_any = 1'b1;
        inv_way = WAYW'(w);
      end
      if (age_q[req_set][w] == AGEW'(WAYS - 1)) lru_way = WAYW'(w);
    end
    victim_way = inv_any ? inv_way : lru_way;
  end

  // Next-state, outputs and storage updates
  always_comb begin
    state_d  = state_q;
    hit_d    = 1'b0;
    stall_d  = stall_q;
    wb_d     = wb_q;
    fetch_d  = fetch_q;
    crow_d   = crow_q;
    mrow_d   = mrow_q;
    lrow_d   = lrow_q;
    lwr_d    = lwr_q;
    victim_d = victim_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    age_d    = age_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit_any) begin
            hit_d          = 1'b1;
            stall_d        = 1'b0;
            crow_d         = crow_of(req_set, hit_way);
            age_d[req_set] = lru_touch(age_q[req_set], hit_way);
            if (WR) dirty_d[req_set][hit_way] = 1'b1;
          end else begin
            lrow_d   = RowId;
            lwr_d    = WR;
            victim_d = victim_way;
            stall_d  = 1'b1;
            if (valid_q[req_set][victim_way] && dirty_q[req_set][victim_way]) begin
              state_d = S_WB;
              wb_d    = 1'b1;
              mrow_d  = {tag_q[req_set][victim_way], req_set};
            end else begin
              state_d = S_FILL;
              fetch_d = 1'b1;
              mrow_d  = RowId;
            end
          end
        end
      end

      S_WB: begin
        if (sync) begin
          wb_d                    = 1'b0;
          dirty_d[lset][victim_q] = 1'b0;
          state_d                 = S_FILL;
          fetch_d                 = 1'b1;
          mrow_d                  = lrow_q;
        end
      end

      S_FILL: begin
        if (sync) begin
          fetch_d                 = 1'b0;
          stall_d                 = 1'b0;
          crow_d                  = crow_of(lset, victim_q);
          valid_d[lset][victim_q] = 1'b1;
          tag_d[lset][victim_q]   = ltag;
          dirty_d[lset][victim_q] = lwr_q;
          age_d[lset]             = lru_touch(age_q[lset], victim_q);
          state_d                 = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registers; reset aborts any wb/fetch in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hit_q    <= 1'b0;
      stall_q  <= 1'b0;
      wb_q     <= 1'b0;
      fetch_q  <= 1'b0;
      crow_q   <= '0;
      mrow_q   <= '0;
      lrow_q   <= '0;
      lwr_q    <= 1'b0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      tag_q    <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[s][w] <= AGEW'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      stall_q  <= stall_d;
      wb_q     <= wb_d;
      fetch_q  <= fetch_d;
      crow_q   <= crow_d;
      mrow_q   <= mrow_d;
      lrow_q   <= lrow_d;
      lwr_q    <= lwr_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      age_q    <= age_d;
    end
  end

  assign cRowId = crow_q;
  assign stall  = stall_q;
  assign hit    = hit_q;
  assign wb     = wb_q;
  assign fetch  = fetch_q;
  assign mRowId = mrow_q;

endmodule

// File: tb/tb_memsync_assoc.sv
// Bench for memsync_assoc (default parameters: 16 sets x 4 ways, 17-bit rows).
// Reference model: per-way valid/dirty/tag plus a last-use timestamp; the
// least recently used way is the valid way with the oldest timestamp.
module tb_memsync_assoc;

  localparam int SETS = 16;
  localparam int WAYS = 4;

  logic        clk;
  logic        rst;
  logic        RD;
  logic        WR;
  logic [16:0] RowId;
  logic        sync;
  logic [5:0]  cRowId;
  logic        stall;
  logic        hit;
  logic        wb;
  logic        fetch;
  logic [16:0] mRowId;

  int vectors;
  int miscompares;

  // Reference model state
  bit      m_valid [SETS][WAYS];
  bit      m_dirty [SETS][WAYS];
  int      m_tag   [SETS][WAYS];
  longint  m_stamp [SETS][WAYS];
  longint  m_now;
  logic [5:0]  m_crow;
  logic [16:0] m_mrow;

  memsync_assoc #(.CHWIDTH(6), .WAYWIDTH(2), .ADDRWIDTH(17)) dut (
    .clk(clk), .rst(rst), .RD(RD), .WR(WR), .RowId(RowId), .sync(sync),
    .cRowId(cRowId), .stall(stall), .hit(hit), .wb(wb), .fetch(fetch),
    .mRowId(mRowId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_stamp[s][w] = -longint'(w);
      end
    end
    m_now  = 1;
    m_crow = '0;
    m_mrow = '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; RD = 1'b0; WR = 1'b0; RowId = '0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b0 || wb !== 1'b0 || fetch !== 1'b0 ||
        cRowId !== 6'h0 || mRowId !== 17'h0) begin
      miscompares++;
      $display("FAIL reset: got hit=%b stall=%b wb=%b fetch=%b cRowId=%h mRowId=%h, expected all zero",
               hit, stall, wb, fetch, cRowId, mRowId);
    end
  endtask

  // One request, served either by a hit or by a full miss sequence.
  task automatic test_access(input logic [16:0] rid, input bit rd, input bit wr);
    int s, t, hw, vw, dly;
    logic [16:0] exp_m;
    s  = int'(rid[3:0]);
    t  = int'(rid[16:4]);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    RD = rd; WR = wr; RowId = rid;
    @(posedge clk); #1;
    if (hw >= 0) begin
      vectors++;
      if (hit !== 1'b1 || stall !== 1'b0 || wb !== 1'b0 || fetch !== 1'b0 ||
          cRowId !== 6'(s * WAYS + hw)) begin
        miscompares++;
        $display("FAIL hit_lookup rid=%h: got hit=%b stall=%b wb=%b fetch=%b cRowId=%h, expected hit=1 stall=0 wb=0 fetch=0 cRowId=%h",
                 rid, hit, stall, wb, fetch, cRowId, 6'(s * WAYS + hw));
      end
      m_stamp[s][hw] = m_now++;
      if (wr) m_dirty[s][hw] = 1'b1;
      m_crow = 6'(s * WAYS + hw);
      RD = 1'b0; WR = 1'b0;
      return;
    end
    vw = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && vw < 0) vw = w;
    if (vw < 0) begin
      vw = 0;
      for (int w = 1; w < WAYS; w++)
        if (m_stamp[s][w] < m_stamp[s][vw]) vw = w;
    end
    if (m_valid[s][vw] && m_dirty[s][vw]) begin
      exp_m = 17'(m_tag[s][vw] * SETS + s);
      vectors++;
      if (hit !== 1'b0 || stall !== 1'b1 || wb !== 1'b1 || fetch !== 1'b0 || mRowId !== exp_m) begin
        miscompares++;
        $display("FAIL wb_start rid=%h: got hit=%b stall=%b wb=%b fetch=%b mRowId=%h, expected hit=0 stall=1 wb=1 fetch=0 mRowId=%h",
                 rid, hit, stall, wb, fetch, mRowId, exp_m);
      end
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) begin
        RD = 1'($urandom); WR = 1'($urandom); RowId = 17'($urandom);
        @(posedge clk); #1;
        vectors++;
        if (wb !== 1'b1 || stall !== 1'b1 || mRowId !== exp_m) begin
          miscompares++;
          $display("FAIL wb_hold rid=%h: got wb=%b stall=%b mRowId=%h, expected wb=1 stall=1 mRowId=%h",
                   rid, wb, stall, mRowId, exp_m);
        end
      end
      sync = 1'b1;
      @(posedge clk); #1;
      sync = 1'b0;
      m_dirty[s][vw] = 1'b0;
    end
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b1 || wb !== 1'b0 || fetch !== 1'b1 || mRowId !== rid) begin
      miscompares++;
      $display("FAIL fetch_start rid=%h: got hit=%b stall=%b wb=%b fetch=%b mRowId=%h, expected hit=0 stall=1 wb=0 fetch=1 mRowId=%h",
               rid, hit, stall, wb, fetch, mRowId, rid);
    end
    dly = $urandom_range(0, 3);
    for (int i = 0; i < dly; i++) begin
      RD = 1'($urandom); WR = 1'($urandom); RowId = 17'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (fetch !== 1'b1 || stall !== 1'b1 || wb !== 1'b0 || mRowId !== rid) begin
        miscompares++;
        $display("FAIL fetch_hold rid=%h: got fetch=%b stall=%b wb=%b mRowId=%h, expected fetch=1 stall=1 wb=0 mRowId=%h",
                 rid, fetch, stall, wb, mRowId, rid);
      end
    end
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0; RD = 1'b0; WR = 1'b0;
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b0 || wb !== 1'b0 || fetch !== 1'b0 ||
        cRowId !== 6'(s * WAYS + vw)) begin
      miscompares++;
      $display("FAIL fill_done rid=%h: got hit=%b stall=%b wb=%b fetch=%b cRowId=%h, expected hit=0 stall=0 wb=0 fetch=0 cRowId=%h",
               rid, hit, stall, wb, fetch, cRowId, 6'(s * WAYS + vw));
    end
    m_valid[s][vw] = 1'b1;
    m_tag[s][vw]   = t;
    m_dirty[s][vw] = wr;
    m_stamp[s][vw] = m_now++;
    m_crow = 6'(s * WAYS + vw);
    m_mrow = rid;
  endtask

  // A held request keeps hitting with unchanged outputs.
  task automatic test_rehit(input logic [16:0] rid, input int cycles);
    int s, hw;
    s  = int'(rid[3:0]);
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == int'(rid[16:4])) hw = w;
    if (hw < 0) return;
    RD = 1'b1; WR = 1'b0; RowId = rid;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (hit !== 1'b1 || stall !== 1'b0 || cRowId !== 6'(s * WAYS + hw)) begin
        miscompares++;
        $display("FAIL rehit rid=%h cycle=%0d: got hit=%b stall=%b cRowId=%h, expected hit=1 stall=0 cRowId=%h",
                 rid, i, hit, stall, cRowId, 6'(s * WAYS + hw));
      end
    end
    m_stamp[s][hw] = m_now++;
    m_crow = 6'(s * WAYS + hw);
    RD = 1'b0;
  endtask

  // sync while idle and no request: nothing moves, hit drops.
  task automatic test_sync_idle();
    RD = 1'b0; WR = 1'b0; RowId = 17'($urandom);
    @(posedge clk); #1;
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b0 || wb !== 1'b0 || fetch !== 1'b0 ||
        cRowId !== m_crow || mRowId !== m_mrow) begin
      miscompares++;
      $display("FAIL sync_idle: got hit=%b stall=%b wb=%b fetch=%b cRowId=%h mRowId=%h, expected hit=0 stall=0 wb=0 fetch=0 cRowId=%h mRowId=%h",
               hit, stall, wb, fetch, cRowId, mRowId, m_crow, m_mrow);
    end
  endtask

  task automatic test_basic();
    test_reset();
    test_access(17'h01234, 1'b0, 1'b1);
    vectors++;
    if (cRowId !== 6'h10) begin
      miscompares++;
      $display("FAIL basic_row: got cRowId=%h, expected 10", cRowId);
    end
    test_access(17'h01234, 1'b0, 1'b1);
    test_rehit(17'h01234, 3);
  endtask

  task automatic test_set_fill_and_evict();
    test_reset();
    test_access(17'h00010, 1'b0, 1'b1);
    test_access(17'h00020, 1'b0, 1'b1);
    test_access(17'h00030, 1'b0, 1'b1);
    test_access(17'h00040, 1'b0, 1'b1);
    test_access(17'h00050, 1'b1, 1'b0);
    vectors++;
    if (cRowId !== 6'h00) begin
      miscompares++;
      $display("FAIL dirty_evict_row: got cRowId=%h, expected 00", cRowId);
    end
  endtask

  task automatic test_lru();
    test_reset();
    test_access(17'h00010, 1'b1, 1'b0);
    test_access(17'h00020, 1'b1, 1'b0);
    test_access(17'h00030, 1'b1, 1'b0);
    test_access(17'h00040, 1'b1, 1'b0);
    test_access(17'h00010, 1'b1, 1'b0);
    test_access(17'h00050, 1'b1, 1'b0);
    vectors++;
    if (cRowId !== 6'h01) begin
      miscompares++;
      $display("FAIL lru_victim: got cRowId=%h, expected 01", cRowId);
    end
  endtask

  task automatic test_reset_mid_wb();
    test_reset();
    test_access(17'h00010, 1'b0, 1'b1);
    test_access(17'h00020, 1'b0, 1'b1);
    test_access(17'h00030, 1'b0, 1'b1);
    test_access(17'h00040, 1'b0, 1'b1);
    RD = 1'b1; WR = 1'b0; RowId = 17'h00050;
    @(posedge clk); #1;
    vectors++;
    if (wb !== 1'b1 || mRowId !== 17'h00010) begin
      miscompares++;
      $display("FAIL pre_reset_wb: got wb=%b mRowId=%h, expected wb=1 mRowId=00010", wb, mRowId);
    end
    rst = 1'b1; RD = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b0 || wb !== 1'b0 || fetch !== 1'b0 ||
        cRowId !== 6'h0 || mRowId !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_mid_wb: got hit=%b stall=%b wb=%b fetch=%b cRowId=%h mRowId=%h, expected all zero",
               hit, stall, wb, fetch, cRowId, mRowId);
    end
    test_access(17'h00010, 1'b1, 1'b0);
  endtask

  task automatic test_rdwr_dirty();
    test_reset();
    test_access(17'h00010, 1'b1, 1'b1);
    test_access(17'h00020, 1'b1, 1'b0);
    test_access(17'h00030, 1'b1, 1'b0);
    test_access(17'h00040, 1'b1, 1'b0);
    test_access(17'h00050, 1'b1, 1'b0);
    test_sync_idle();
  endtask

  task automatic test_random();
    logic [16:0] rid;
    int op;
    test_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) rid = 17'($urandom);
      else rid = 17'($urandom_range(0, 5) * SETS + $urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      test_access(rid, op != 2, op >= 2);
      if ($urandom_range(0, 15) == 0) test_sync_idle();
      if ($urandom_range(0, 15) == 0) test_rehit(rid, 2);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; RD = 1'b0; WR = 1'b0; RowId = '0; sync = 1'b0;
    model_reset();
    test_basic();
    test_set_fill_and_evict();
    test_lru();
    test_reset_mid_wb();
    test_rdwr_dirty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
